// File: rtl/extend_pkg.sv
// ============================================================================
// Module      : extend_pkg
// Description : Mode encodings, default width and lane helper for extend_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package extend_pkg;

    localparam int EXT_DATA_W_DEF = 32;
    localparam int EXT_MAX_W      = 64;

    localparam logic [2:0] EXT_SEXT = 3'd0;
    localparam logic [2:0] EXT_ZEXT = 3'd1;
    localparam logic [2:0] EXT_LUI  = 3'd2;
    localparam logic [2:0] EXT_LB   = 3'd3;
    localparam logic [2:0] EXT_LBU  = 3'd4;
    localparam logic [2:0] EXT_LH   = 3'd5;
    localparam logic [2:0] EXT_LHU  = 3'd6;
    localparam logic [2:0] EXT_PASS = 3'd7;

    // Little-endian byte lane select; callers zero-extend narrower words.
    function automatic logic [7:0] get_byte(input logic [EXT_MAX_W-1:0] word,
                                            input logic [2:0]           lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/extend_core.sv
// ============================================================================
// Module      : extend_core
// Description : Combinational mode/lane/extend logic for extend_unit.
//               Optional: EXTEND_MISALIGN_CHECK_EN adds the misalign output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module extend_core
    import extend_pkg::*;
#(
    parameter int  DATA_W = EXT_DATA_W_DEF,
    parameter int  IMM_W  = 16,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
`ifdef EXTEND_MISALIGN_CHECK_EN
    output logic              misalign,
`endif
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  offset,
    output logic [DATA_W-1:0] result
);

    logic [EXT_MAX_W-1:0] w_wide;
    logic [IMM_W-1:0]     w_imm;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;

    assign w_wide = EXT_MAX_W'(data);
    assign w_imm  = data[IMM_W-1:0];
    assign w_byte = get_byte(w_wide, 3'(offset));
    assign w_half = {get_byte(w_wide, 3'({offset[OFF_W-1:1], 1'b1})),
                     get_byte(w_wide, 3'({offset[OFF_W-1:1], 1'b0}))};

    always_comb begin
        result = data;
        case (mode)
            EXT_SEXT: result = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
            EXT_ZEXT: result = {{(DATA_W-IMM_W){1'b0}}, w_imm};
            EXT_LUI:  result = {w_imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_LB:   result = {{(DATA_W-8){w_byte[7]}}, w_byte};
            EXT_LBU:  result = {{(DATA_W-8){1'b0}}, w_byte};
            EXT_LH:   result = {{(DATA_W-16){w_half[15]}}, w_half};
            EXT_LHU:  result = {{(DATA_W-16){1'b0}}, w_half};
            default:  result = data;
        endcase
    end

`ifdef EXTEND_MISALIGN_CHECK_EN
    assign misalign = (((mode == EXT_LH) || (mode == EXT_LHU)) && offset[0]) ||
                      ((mode == EXT_PASS) && (offset != '0));
`endif

endmodule

`default_nettype wire

// File: rtl/extend_unit.sv
// ============================================================================
// Module      : extend_unit
// Description : Registered operand extender with 2-entry skid buffer.
//               Optional: EXTEND_MISALIGN_CHECK_EN enables out_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module extend_unit
    import extend_pkg::*;
#(
    parameter int  DATA_W = EXT_DATA_W_DEF,
    parameter int  IMM_W  = 16,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misalign
);

    logic [DATA_W-1:0] w_result;
    logic              w_accept;
    logic              w_main_from_skid;
    logic              w_main_from_in;
    logic              w_main_drain;
    logic              w_skid_from_in;

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;

`ifdef EXTEND_MISALIGN_CHECK_EN
    logic              w_misalign;
    logic              r_skid_mis;
`endif

    extend_core #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_core (
`ifdef EXTEND_MISALIGN_CHECK_EN
        .misalign (w_misalign),
`endif
        .mode     (in_mode),
        .data     (in_data),
        .offset   (in_offset),
        .result   (w_result)
    );

    // in_ready mirrors !skid_valid, so an accept always finds the skid empty.
    assign w_accept         = in_valid && in_ready;
    assign w_main_from_skid = r_skid_valid && out_ready;
    assign w_main_from_in   = !r_skid_valid && (!out_valid || out_ready) && w_accept;
    assign w_main_drain     = !r_skid_valid && out_valid && out_ready && !w_accept;
    assign w_skid_from_in   = !r_skid_valid && out_valid && !out_ready && w_accept;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            in_ready     <= 1'b1;
        end else begin
            if (w_main_from_skid) begin
                out_data     <= r_skid_data;
                r_skid_valid <= 1'b0;
                in_ready     <= 1'b1;
            end else if (w_main_from_in) begin
                out_valid    <= 1'b1;
                out_data     <= w_result;
            end else if (w_main_drain) begin
                out_valid    <= 1'b0;
            end else if (w_skid_from_in) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_result;
                in_ready     <= 1'b0;
            end
        end
    end

`ifdef EXTEND_MISALIGN_CHECK_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_misalign <= 1'b0;
            r_skid_mis   <= 1'b0;
        end else begin
            if (w_main_from_skid) begin
                out_misalign <= r_skid_mis;
            end else if (w_main_from_in) begin
                out_misalign <= w_misalign;
            end else if (w_skid_from_in) begin
                r_skid_mis   <= w_misalign;
            end
        end
    end
`else
    assign out_misalign = 1'b0;
`endif

endmodule

`default_nettype wire
